// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the MEM-stage data-memory controller
//
// Purpose: FSM state encodings and the default value returned for an aborted
//          or misaligned load.
// Contents:
//   ST_IDLE, ST_BUSY, ST_DONE  2-bit state constants
//   ERR_DATA_DEFAULT           32-bit default for the ERR_DATA parameter
package cpu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mem_dram_ctrl_if.sv
// rtl/mem_dram_ctrl_if.sv - single-word request/acknowledge data-memory bus
//
// Purpose: groups the data-memory bus signals between the MEM-stage
//          controller (master) and the memory responder (slave).
// Signals:
//   bus_req    master->slave  transaction request
//   bus_we     master->slave  1 = write, 0 = read; valid while bus_req
//   bus_addr   master->slave  word-aligned address; valid while bus_req
//   bus_wdata  master->slave  write data; valid while bus_req && bus_we
//   bus_ack    slave->master  completion; only meaningful while bus_req
//   bus_rdata  slave->master  read data; valid with bus_ack on reads
interface mem_dram_ctrl_if #(
  parameter int AW = 32
) ();

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic [31:0]   bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - wait-cycle counter for an outstanding bus access
//
// Purpose: counts BUSY cycles without acknowledge; flags the last allowed one.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous, active-low reset
//   clear    in   force count to zero (held while the controller is idle)
//   enable   in   advance the count by one
//   expired  out  count has reached TIMEOUT-1 (last BUSY cycle before abort)
module mem_timeout_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // One spare bit so the count never wraps before it meets TIMEOUT-1.
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_dram_ctrl.sv
// rtl/mem_dram_ctrl.sv - MEM-stage load/store to data-memory bus controller
//
// Purpose: turns a MEM-stage load or store into one request/acknowledge bus
//          transaction, stalls the pipeline while it is outstanding, returns
//          registered load data, and aborts misaligned or timed-out accesses.
// Ports:
//   clk, reset        clock; asynchronous active-low reset
//   mem_have_inst     valid instruction in MEM
//   mem_mem2reg       instruction is a load
//   mem_dram_we       instruction is a store (wins over mem_mem2reg)
//   mem_result        byte address
//   mem_rd2           store data
//   bus               data-memory bus, master side
//   mem_stall         freeze upstream pipeline registers this cycle
//   mem_rdata         registered load result
//   mem_rdata_valid   one-cycle pulse: mem_rdata updated for a load
//   mem_err           one-cycle pulse: access aborted
//   err_misalign      sticky misaligned-access flag
//   err_timeout       sticky timeout flag
module mem_dram_ctrl
  import cpu_pkg::*;
#(
  parameter int          AW       = 32,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_have_inst,
  input  logic                   mem_mem2reg,
  input  logic                   mem_dram_we,
  input  logic [31:0]            mem_result,
  input  logic [31:0]            mem_rd2,
  mem_dram_ctrl_if.master        bus,
  output logic                   mem_stall,
  output logic [31:0]            mem_rdata,
  output logic                   mem_rdata_valid,
  output logic                   mem_err,
  output logic                   err_misalign,
  output logic                   err_timeout
);

  logic [1:0] state;
  logic       acc;
  logic       is_store;
  logic       misaligned;
  logic       expired;

  assign acc        = mem_have_inst & (mem_mem2reg | mem_dram_we);
  assign is_store   = mem_dram_we;
  assign misaligned = (mem_result[1:0] != 2'b00);

  // DONE is the cycle the pipeline advances, so it is the only access cycle
  // without a stall.
  assign mem_stall = acc & (state != ST_DONE);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ST_IDLE),
    .enable  ((state == ST_BUSY) & ~bus.bus_ack & ~expired),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      bus.bus_req     <= 1'b0;
      bus.bus_we      <= 1'b0;
      bus.bus_addr    <= '0;
      bus.bus_wdata   <= '0;
      mem_rdata       <= '0;
      mem_rdata_valid <= 1'b0;
      mem_err         <= 1'b0;
      err_misalign    <= 1'b0;
      err_timeout     <= 1'b0;
    end else begin
      // Pulses are set only on the edge into DONE, so they last one cycle.
      mem_rdata_valid <= 1'b0;
      mem_err         <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (acc) begin
            if (misaligned) begin
              state        <= ST_DONE;
              mem_err      <= 1'b1;
              err_misalign <= 1'b1;
              if (!is_store) begin
                mem_rdata       <= ERR_DATA;
                mem_rdata_valid <= 1'b1;
              end
            end else begin
              state         <= ST_BUSY;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= is_store;
              bus.bus_addr  <= AW'(mem_result);
              bus.bus_wdata <= mem_rd2;
            end
          end
        end

        ST_BUSY: begin
          // bus_we doubles as the load/store record for the access in flight.
          if (bus.bus_ack) begin
            state       <= ST_DONE;
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) begin
              mem_rdata       <= bus.bus_rdata;
              mem_rdata_valid <= 1'b1;
            end
          end else if (expired) begin
            state       <= ST_DONE;
            bus.bus_req <= 1'b0;
            mem_err     <= 1'b1;
            err_timeout <= 1'b1;
            if (!bus.bus_we) begin
              mem_rdata       <= ERR_DATA;
              mem_rdata_valid <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dram_ctrl.sv
// tb/tb_mem_dram_ctrl.sv - directed self-checking bench for mem_dram_ctrl
//
// Purpose: drives MEM-stage loads/stores and a hand-played responder, and
//          checks bus, stall, data and error outputs against hand-computed
//          values (TIMEOUT=16, ERR_DATA=32'hEEEE_0001).
module tb_mem_dram_ctrl;

  localparam logic [31:0] ERRV = 32'hEEEE_0001;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_have_inst = 1'b0;
  logic        mem_mem2reg = 1'b0;
  logic        mem_dram_we = 1'b0;
  logic [31:0] mem_result = '0;
  logic [31:0] mem_rd2 = '0;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_err;
  logic        err_misalign;
  logic        err_timeout;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_dram_ctrl_if #(.AW(32)) bus_if ();

  mem_dram_ctrl #(
    .AW       (32),
    .TIMEOUT  (16),
    .ERR_DATA (ERRV)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_have_inst   (mem_have_inst),
    .mem_mem2reg     (mem_mem2reg),
    .mem_dram_we     (mem_dram_we),
    .mem_result      (mem_result),
    .mem_rd2         (mem_rd2),
    .bus             (bus_if),
    .mem_stall       (mem_stall),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_err         (mem_err),
    .err_misalign    (err_misalign),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_inst(input logic h, input logic ld, input logic st,
                          input logic [31:0] a, input logic [31:0] d);
    mem_have_inst = h;
    mem_mem2reg   = ld;
    mem_dram_we   = st;
    mem_result    = a;
    mem_rd2       = d;
    #1;
  endtask

  initial begin
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;

    // Reset values
    cyc();
    cyc();
    chk("rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_addr", bus_if.bus_addr, 32'd0);
    chk("rst_wdata", bus_if.bus_wdata, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_flags", {28'd0, mem_rdata_valid, mem_err, err_misalign, err_timeout}, 32'd0);
    reset = 1'b1;

    // Load 0x100, ack in first BUSY cycle
    cyc();
    set_inst(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    chk("ld_idle_stall", 32'(mem_stall), 32'd1);
    chk("ld_idle_req", 32'(bus_if.bus_req), 32'd0);
    cyc();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D; #1;
    chk("ld_busy_req", 32'(bus_if.bus_req), 32'd1);
    chk("ld_busy_we", 32'(bus_if.bus_we), 32'd0);
    chk("ld_busy_addr", bus_if.bus_addr, 32'h100);
    chk("ld_busy_stall", 32'(mem_stall), 32'd1);
    cyc();
    bus_if.bus_ack = 1'b0; #1;
    chk("ld_done_stall", 32'(mem_stall), 32'd0);
    chk("ld_done_req", 32'(bus_if.bus_req), 32'd0);
    chk("ld_done_rdata", mem_rdata, 32'hCAFE_F00D);
    chk("ld_done_valid", 32'(mem_rdata_valid), 32'd1);
    chk("ld_done_err", 32'(mem_err), 32'd0);

    // Store 0x12345678 to 0x204, ack after 3 wait cycles
    cyc();
    chk("ld_after_valid", 32'(mem_rdata_valid), 32'd0);
    set_inst(1'b1, 1'b0, 1'b1, 32'h204, 32'h1234_5678);
    chk("st_idle_stall", 32'(mem_stall), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin
        bus_if.bus_ack = 1'b1; #1;
      end
      chk($sformatf("st_busy%0d_req", i), 32'(bus_if.bus_req), 32'd1);
      chk($sformatf("st_busy%0d_we", i), 32'(bus_if.bus_we), 32'd1);
      chk($sformatf("st_busy%0d_addr", i), bus_if.bus_addr, 32'h204);
      chk($sformatf("st_busy%0d_wdata", i), bus_if.bus_wdata, 32'h1234_5678);
      chk($sformatf("st_busy%0d_stall", i), 32'(mem_stall), 32'd1);
    end
    cyc();
    bus_if.bus_ack = 1'b0; #1;
    chk("st_done_stall", 32'(mem_stall), 32'd0);
    chk("st_done_req", 32'(bus_if.bus_req), 32'd0);
    chk("st_done_valid", 32'(mem_rdata_valid), 32'd0);
    chk("st_done_err", 32'(mem_err), 32'd0);
    chk("st_done_rdata", mem_rdata, 32'hCAFE_F00D);

    // Misaligned load at 0x102
    cyc();
    set_inst(1'b1, 1'b1, 1'b0, 32'h102, 32'h0);
    chk("mis_idle_stall", 32'(mem_stall), 32'd1);
    cyc();
    chk("mis_done_req", 32'(bus_if.bus_req), 32'd0);
    chk("mis_done_stall", 32'(mem_stall), 32'd0);
    chk("mis_done_err", 32'(mem_err), 32'd1);
    chk("mis_done_valid", 32'(mem_rdata_valid), 32'd1);
    chk("mis_done_rdata", mem_rdata, ERRV);
    chk("mis_done_sticky", 32'(err_misalign), 32'd1);
    cyc();
    set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mis_after_err", 32'(mem_err), 32'd0);
    chk("mis_after_sticky", 32'(err_misalign), 32'd1);
    chk("mis_after_req", 32'(bus_if.bus_req), 32'd0);

    // Load 0x300 with no ack: 16 BUSY cycles then abort
    set_inst(1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    chk("to_idle_stall", 32'(mem_stall), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("to_busy%0d_req", i), 32'(bus_if.bus_req), 32'd1);
      chk($sformatf("to_busy%0d_stall", i), 32'(mem_stall), 32'd1);
    end
    cyc();
    chk("to_done_req", 32'(bus_if.bus_req), 32'd0);
    chk("to_done_stall", 32'(mem_stall), 32'd0);
    chk("to_done_err", 32'(mem_err), 32'd1);
    chk("to_done_valid", 32'(mem_rdata_valid), 32'd1);
    chk("to_done_rdata", mem_rdata, ERRV);
    chk("to_done_sticky", 32'(err_timeout), 32'd1);
    // Late ack one cycle after DONE must be ignored
    cyc();
    set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h7777_7777; #1;
    chk("late_req", 32'(bus_if.bus_req), 32'd0);
    chk("late_stall", 32'(mem_stall), 32'd0);
    cyc();
    bus_if.bus_ack = 1'b0; #1;
    chk("late_valid", 32'(mem_rdata_valid), 32'd0);
    chk("late_rdata", mem_rdata, ERRV);
    chk("late_req2", 32'(bus_if.bus_req), 32'd0);

    // Back-to-back load 0x400 then store (both type bits set) to 0x404
    set_inst(1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    chk("b2b_c0_stall", 32'(mem_stall), 32'd1);
    cyc();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hA5A5_0001; #1;
    chk("b2b_c1_stall", 32'(mem_stall), 32'd1);
    chk("b2b_c1_req", 32'(bus_if.bus_req), 32'd1);
    cyc();
    bus_if.bus_ack = 1'b0; #1;
    chk("b2b_c2_stall", 32'(mem_stall), 32'd0);
    chk("b2b_c2_rdata", mem_rdata, 32'hA5A5_0001);
    chk("b2b_c2_valid", 32'(mem_rdata_valid), 32'd1);
    cyc();
    set_inst(1'b1, 1'b1, 1'b1, 32'h404, 32'hDEAD_BEEF);
    chk("b2b_c3_stall", 32'(mem_stall), 32'd1);
    chk("b2b_c3_req", 32'(bus_if.bus_req), 32'd0);
    chk("b2b_c3_valid", 32'(mem_rdata_valid), 32'd0);
    cyc();
    bus_if.bus_ack = 1'b1; #1;
    chk("b2b_c4_stall", 32'(mem_stall), 32'd1);
    chk("b2b_c4_we", 32'(bus_if.bus_we), 32'd1);
    chk("b2b_c4_addr", bus_if.bus_addr, 32'h404);
    chk("b2b_c4_wdata", bus_if.bus_wdata, 32'hDEAD_BEEF);
    cyc();
    bus_if.bus_ack = 1'b0; #1;
    chk("b2b_c5_stall", 32'(mem_stall), 32'd0);
    chk("b2b_c5_valid", 32'(mem_rdata_valid), 32'd0);
    chk("b2b_c5_err", 32'(mem_err), 32'd0);

    // Reset during the 2nd BUSY cycle of a load to 0x500
    cyc();
    set_inst(1'b1, 1'b1, 1'b0, 32'h500, 32'h0);
    cyc();
    cyc();
    chk("rb_busy2_req", 32'(bus_if.bus_req), 32'd1);
    reset = 1'b0; #1;
    chk("rb_rst_req", 32'(bus_if.bus_req), 32'd0);
    chk("rb_rst_stall", 32'(mem_stall), 32'd1);
    chk("rb_rst_rdata", mem_rdata, 32'd0);
    chk("rb_rst_sticky", {30'd0, err_misalign, err_timeout}, 32'd0);
    chk("rb_rst_addr", bus_if.bus_addr, 32'd0);
    cyc();
    reset = 1'b1; #1;
    chk("rb_idle_stall", 32'(mem_stall), 32'd1);
    chk("rb_idle_req", 32'(bus_if.bus_req), 32'd0);
    cyc();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h600D_F00D; #1;
    chk("rb_busy_req", 32'(bus_if.bus_req), 32'd1);
    chk("rb_busy_addr", bus_if.bus_addr, 32'h500);
    cyc();
    bus_if.bus_ack = 1'b0; #1;
    chk("rb_done_rdata", mem_rdata, 32'h600D_F00D);
    chk("rb_done_valid", 32'(mem_rdata_valid), 32'd1);
    chk("rb_done_stall", 32'(mem_stall), 32'd0);
    cyc();
    set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
